zintack_snoop: RTL and testbench

//  CPU-side end of the Z80 IM2 interrupt protocol. Detects the INTACK cycle and drives the
//  IM2 vector onto the CPU data bus. Snoops M1 opcode fetches for RETI/RETN and tracks ISR

---
 rtl/zintack_snoop.sv | 149 ++++++++++++++
 tb/tb_zintack_snoop.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/zintack_snoop.sv
// zintack_snoop: CPU-side end of the Z80 IM2 interrupt protocol.
//   Detects the INTACK cycle and drives the IM2 vector onto the CPU data bus.
//   Snoops M1 opcode fetches for RETI/RETN and tracks ISR nesting depth.
// Ports:
//   clk, res          system clock, synchronous active-high reset
//   zpos              Z80 clock positive-edge strobe; bus inputs sampled only when 1
//   m1_n, mreq_n,     Z80 bus control strobes (active low)
//   iorq_n, rd_n
//   di                CPU data bus, snooped during opcode fetch
//   im2vect           vector from the interrupt controller
//   intack            high for the duration of the acknowledge cycle
//   dout, dout_oe     vector driven to the CPU and its enable
//   reti, retn        1-clk pulses on RETI / RETN (and aliases) fetch
//   isr_depth         current ISR nesting depth (saturating)
//   isr_active        isr_depth != 0
module zintack_snoop #(
  parameter int unsigned DEPTH_W = 3
) (
  input  logic               clk,
  input  logic               res,
  input  logic               zpos,
  input  logic               m1_n,
  input  logic               mreq_n,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic [7:0]         di,
  input  logic [7:0]         im2vect,
  output logic               intack,
  output logic [7:0]         dout,
  output logic               dout_oe,
  output logic               reti,
  output logic               retn,
  output logic [DEPTH_W-1:0] isr_depth,
  output logic               isr_active
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);

  typedef enum logic {ST_IDLE, ST_PFX_ED} state_e;

  state_e             state_q;
  logic               intack_q;
  logic [7:0]         dout_q;
  logic               dout_oe_q;
  logic               reti_q;
  logic               retn_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               armed_q;
  logic               in_fetch_q;
  logic [7:0]         opcode_q;

  logic               intack_d;
  logic               dout_oe_d;
  logic               fetch_act;
  logic               fetch_end;
  logic               reti_d;
  logic               retn_d;
  logic               is_retn_op;
  logic               depth_inc;
  logic               depth_dec;

  // Strobes derived from the current bus sample and registered state
  always_comb begin
    intack_d   = intack_q;
    fetch_act  = 1'b0;
    fetch_end  = 1'b0;
    reti_d     = 1'b0;
    retn_d     = 1'b0;
    is_retn_op = 1'b0;
    if (zpos) begin
      intack_d  = ~m1_n & ~iorq_n;
      fetch_act = ~m1_n & ~mreq_n & ~rd_n;
      // Opcode is decoded on the first sample with MREQ released
      fetch_end = mreq_n & in_fetch_q;
    end
    // ED 45/55/5D/65/6D/75/7D all match 01xx x101 except 4D (RETI)
    is_retn_op = (opcode_q[7:6] == 2'b01) && (opcode_q[2:0] == 3'b101) &&
                 (opcode_q != 8'h4D);
    if (fetch_end && state_q == ST_PFX_ED) begin
      reti_d = (opcode_q == 8'h4D);
      retn_d = is_retn_op;
    end
    // Enable follows intack by one clk on the way up, drops with it
    dout_oe_d = intack_d & intack_q;
    depth_inc = intack_d & ~intack_q;
    depth_dec = reti_d | retn_d;
  end

  // All state, including the opcode FSM
  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= ST_IDLE;
      intack_q   <= 1'b0;
      dout_q     <= 8'hFF;
      dout_oe_q  <= 1'b0;
      reti_q     <= 1'b0;
      retn_q     <= 1'b0;
      depth_q    <= DEPTH_ZERO;
      armed_q    <= 1'b0;
      in_fetch_q <= 1'b0;
      opcode_q   <= 8'h00;
    end else begin
      intack_q  <= intack_d;
      dout_oe_q <= dout_oe_d;
      reti_q    <= reti_d;
      retn_q    <= retn_d;
      if (dout_oe_d && !dout_oe_q) begin
        dout_q <= im2vect;
      end

      if (zpos && mreq_n) begin
        armed_q <= 1'b1;
      end

      // A fetch already in progress when arming happens is never tracked
      if (fetch_act && armed_q) begin
        in_fetch_q <= 1'b1;
        opcode_q   <= di;
      end else if (fetch_end) begin
        in_fetch_q <= 1'b0;
      end

      if (fetch_end) begin
        case (state_q)
          ST_IDLE:   state_q <= (opcode_q == 8'hED) ? ST_PFX_ED : ST_IDLE;
          ST_PFX_ED: state_q <= ST_IDLE;
          default:   state_q <= ST_IDLE;
        endcase
      end

      if (depth_inc && !depth_dec && depth_q != DEPTH_MAX) begin
        depth_q <= depth_q + DEPTH_ONE;
      end else if (depth_dec && !depth_inc && depth_q != DEPTH_ZERO) begin
        depth_q <= depth_q - DEPTH_ONE;
      end
    end
  end

  assign intack     = intack_q;
  assign dout       = dout_q;
  assign dout_oe    = dout_oe_q;
  assign reti       = reti_q;
  assign retn       = retn_q;
  assign isr_depth  = depth_q;
  assign isr_active = (depth_q != DEPTH_ZERO);

endmodule

// File: tb/tb_zintack_snoop.sv
// tb_zintack_snoop: self-checking bench for zintack_snoop.
//   Opcode sequences come from a vector table; expected RETI/RETN pulses are
//   queued when a sequence is driven and popped by a pulse monitor.
module tb_zintack_snoop;

  localparam int unsigned DEPTH_W = 3;

  logic               clk = 1'b0;
  logic               res;
  logic               zpos;
  logic               m1_n, mreq_n, iorq_n, rd_n;
  logic [7:0]         di, im2vect;
  logic               intack;
  logic [7:0]         dout;
  logic               dout_oe, reti, retn;
  logic [DEPTH_W-1:0] isr_depth;
  logic               isr_active;

  int checks = 0;
  int errors = 0;
  int exp_q[$];   // 1 = reti pulse, 2 = retn pulse

  always #5 clk = ~clk;

  zintack_snoop #(.DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .res(res), .zpos(zpos),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .di(di), .im2vect(im2vect),
    .intack(intack), .dout(dout), .dout_oe(dout_oe),
    .reti(reti), .retn(retn),
    .isr_depth(isr_depth), .isr_active(isr_active)
  );

  typedef struct {
    logic [23:0] ops;    // first opcode in [23:16]
    int          n;
    int          pulse;  // 0 none, 1 reti, 2 retn
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: every pulse seen must match the head of the queue
  always @(posedge clk) begin
    logic [31:0] got;
    #2;
    if (reti === 1'b1 || retn === 1'b1) begin
      got = {30'd0, retn, reti};
      if (exp_q.size() == 0) chk("unexpected_pulse", got, 32'd0);
      else                   chk("pulse_kind", got, 32'(exp_q.pop_front()));
    end
  end

  task automatic step(input logic z);
    zpos = z;
    @(posedge clk);
    #1;
  endtask

  task automatic ztick();
    step(1'b1);
    step(1'b0);
  endtask

  task automatic bus_idle();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  // Opcode fetch: two samples, only the last carries the real opcode
  task automatic fetch(input logic [7:0] op);
    m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    di = op ^ 8'hFF;
    ztick();
    di = op;
    ztick();
    bus_idle();
    di = 8'h00;
    ztick();
  endtask

  task automatic intack_cycle();
    m1_n = 1'b0; iorq_n = 1'b0;
    ztick(); ztick(); ztick();
    bus_idle();
    ztick();
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{24'hED4D00, 2, 1};
    vecs[1]  = '{24'hDDED45, 3, 2};
    vecs[2]  = '{24'hEDED4D, 3, 0};
    vecs[3]  = '{24'hED0000, 2, 0};
    vecs[4]  = '{24'hFDED7D, 3, 2};
    vecs[5]  = '{24'hED5500, 2, 2};
    vecs[6]  = '{24'hED5D00, 2, 2};
    vecs[7]  = '{24'hED6500, 2, 2};
    vecs[8]  = '{24'hED6D00, 2, 2};
    vecs[9]  = '{24'hED7500, 2, 2};
    vecs[10] = '{24'hED4E00, 2, 0};
    vecs[11] = '{24'h4D0000, 1, 0};

    res = 1'b1; zpos = 1'b0; bus_idle(); di = 8'h00; im2vect = 8'h00;
    ztick(); ztick();
    chk("rst_intack", 32'(intack), 32'd0);
    chk("rst_dout", 32'(dout), 32'hFF);
    chk("rst_oe", 32'(dout_oe), 32'd0);
    chk("rst_reti", 32'(reti), 32'd0);
    chk("rst_retn", 32'(retn), 32'd0);
    chk("rst_depth", 32'(isr_depth), 32'd0);
    chk("rst_active", 32'(isr_active), 32'd0);
    res = 1'b0;
    ztick();

    // 1) INTACK with vector FD
    im2vect = 8'hFD;
    m1_n = 1'b0; iorq_n = 1'b0;
    step(1'b1);
    chk("t1_intack_rise", 32'(intack), 32'd1);
    chk("t1_oe_lag", 32'(dout_oe), 32'd0);
    chk("t1_depth", 32'(isr_depth), 32'd1);
    step(1'b0);
    chk("t1_oe_rise", 32'(dout_oe), 32'd1);
    chk("t1_dout", 32'(dout), 32'hFD);
    im2vect = 8'h12;
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    chk("t1_intack_hold", 32'(intack), 32'd1);
    chk("t1_dout_hold", 32'(dout), 32'hFD);
    bus_idle();
    step(1'b1);
    chk("t1_intack_fall", 32'(intack), 32'd0);
    chk("t1_oe_fall", 32'(dout_oe), 32'd0);
    chk("t1_dout_keep", 32'(dout), 32'hFD);
    chk("t1_depth_keep", 32'(isr_depth), 32'd1);
    step(1'b0);

    // 2) RETI unwinds depth, then RETI at depth 0
    exp_q.push_back(1);
    fetch(8'hED); fetch(8'h4D);
    chk("t2_depth0", 32'(isr_depth), 32'd0);
    exp_q.push_back(1);
    fetch(8'hED); fetch(8'h4D);
    chk("t2_depth_sat0", 32'(isr_depth), 32'd0);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);

    // 3) Opcode sequence table
    for (int v = 0; v < 12; v++) begin
      logic [23:0] ops;
      ops = vecs[v].ops;
      if (vecs[v].pulse != 0) exp_q.push_back(vecs[v].pulse);
      for (int k = 0; k < vecs[v].n; k++) begin
        fetch(ops[23:16]);
        ops = ops << 8;
      end
      chk($sformatf("vec%0d_pending", v), 32'(exp_q.size()), 32'd0);
      chk($sformatf("vec%0d_depth", v), 32'(isr_depth), 32'd0);
    end

    // 4) Nesting saturation and unwind
    for (int i = 0; i < 8; i++) intack_cycle();
    chk("t4_depth_sat", 32'(isr_depth), 32'd7);
    chk("t4_active", 32'(isr_active), 32'd1);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(1);
      fetch(8'hED); fetch(8'h4D);
    end
    chk("t4_depth_unwind", 32'(isr_depth), 32'd0);
    chk("t4_inactive", 32'(isr_active), 32'd0);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // 5) Reset in PFX_ED mid-fetch with intack high
    im2vect = 8'h5A;
    fetch(8'hED);
    m1_n = 1'b0; iorq_n = 1'b0;
    ztick();
    mreq_n = 1'b0; rd_n = 1'b0; di = 8'h4D;
    ztick();
    chk("t5_pre_intack", 32'(intack), 32'd1);
    chk("t5_pre_oe", 32'(dout_oe), 32'd1);
    res = 1'b1;
    step(1'b1);
    chk("t5_intack", 32'(intack), 32'd0);
    chk("t5_dout", 32'(dout), 32'hFF);
    chk("t5_oe", 32'(dout_oe), 32'd0);
    chk("t5_reti", 32'(reti), 32'd0);
    chk("t5_retn", 32'(retn), 32'd0);
    chk("t5_depth", 32'(isr_depth), 32'd0);
    res = 1'b0;
    iorq_n = 1'b1;
    ztick();          // truncated fetch still on the bus, not armed
    bus_idle();
    ztick(); ztick();
    chk("t5_no_decode", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(1);
    fetch(8'hED); fetch(8'h4D);
    chk("t5_reti_after", 32'(exp_q.size()), 32'd0);

    // 6) Bus activity with zpos held low changes nothing
    zpos = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m1_n   = i[0];
      mreq_n = i[0];
      rd_n   = i[0];
      iorq_n = i[1];
      di     = i[2] ? 8'h4D : 8'hED;
      @(posedge clk); #1;
    end
    chk("t6_intack", 32'(intack), 32'd0);
    chk("t6_oe", 32'(dout_oe), 32'd0);
    chk("t6_depth", 32'(isr_depth), 32'd0);
    bus_idle();
    fetch(8'h4D);     // FSM must still be IDLE: no pulse
    chk("t6_fsm_idle", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(1);
    fetch(8'hED); fetch(8'h4D);
    ztick();
    chk("t6_final_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
